mod_counter_chain: RTL and testbench
====================================

MOD_COUNTER_CHAIN -- requirements
Module: mod_counter_chain

Interface
REQ-001 Parameter DIGITS, default 4: number of cascaded digits, 1..8.
REQ-002 Parameter WIDTH, default 4: bits per digit, 2..8.
REQ-003 Parameter MODS, default {4'd6,4'd10,4'd6,4'd10}: DIGITS*WIDTH packed per-digit modulus, digit 0 in LSBs; each value is 2..2^WIDTH.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 async_nreset  input  1  reset, asynchronous, active-low.
REQ-006 ctrl  input  3  operation select: 0 NONE, 1 INCR, 2 LOAD, 3 CLR, 4 DECR; 5..7 behave as NONE.
REQ-007 data_in  input  DIGITS*WIDTH  load value, digit 0 in LSBs.
REQ-008 data_out  output  DIGITS*WIDTH  current digit registers, digit 0 in LSBs.
REQ-009 wrap  output  1  registered one-cycle pulse: previous operation wrapped the whole chain.
REQ-010 zero  output  1  combinational: all digits equal 0.

Function
REQ-011 NONE SHALL hold all digits; wrap SHALL be 0 in the following cycle.
REQ-012 INCR SHALL increment digit 0; digit i>0 SHALL increment only when every lower digit equals its MOD-1.
REQ-013 An incrementing digit at MOD-1 SHALL become 0 (carry); other digits SHALL hold.
REQ-014 DECR SHALL decrement digit 0; digit i>0 SHALL decrement only when every lower digit equals 0.
REQ-015 A decrementing digit at 0 SHALL become MOD-1 (borrow).
REQ-016 LOAD SHALL write data_in per digit; a field >= its modulus SHALL be saturated to MOD-1.
REQ-017 CLR SHALL set all digits to 0.
REQ-018 All updates SHALL take effect one clock after ctrl is sampled; data_out latency is 1 cycle.
REQ-019 wrap SHALL be 1 in the cycle after an INCR with all digits at MOD-1, or a DECR with all digits at 0; otherwise 0.
REQ-020 LOAD and CLR SHALL never assert wrap.
REQ-021 zero SHALL reflect data_out with no register stage.
REQ-022 Carry/borrow enables SHALL be computed combinationally from current digit values within one cycle; no ripple across clocks.
REQ-023 Digit arithmetic SHALL be WIDTH bits and never produce a value >= its modulus.

Reset
REQ-024 async_nreset low SHALL immediately clear all digits to 0 and wrap to 0, regardless of clk.
REQ-025 Reset asserted mid-count SHALL discard any pending carry, borrow or wrap.
REQ-026 After release, the first rising edge SHALL execute ctrl normally.

Structure
REQ-027 Package mod_counter_pkg SHALL hold the ctrl encodings (CTRL_NONE, CTRL_INCR, CTRL_LOAD, CTRL_CLR, CTRL_DECR) and the ctrl width.
REQ-028 Sub-module mod_digit SHALL be instantiated DIGITS times.
REQ-029 mod_digit SHALL take parameters WIDTH and MOD; inputs inc_en, dec_en, load, clr, d; outputs q, at_max, at_zero.
REQ-030 The top SHALL generate the enable chains and register wrap.

Verification (DIGITS=4, WIDTH=4, default MODS)
REQ-031 Reset low, then released -> data_out=0x0000, zero=1, wrap=0.
REQ-032 LOAD 0x5959, then INCR -> data_out=0x0000, wrap=1 for exactly one cycle, zero=1.
REQ-033 LOAD 0x0959, then INCR -> 0x1000; LOAD 0x0009, then INCR -> 0x0010; wrap=0 in both cases.
REQ-034 CLR, then DECR -> 0x5959, wrap=1 one cycle; a second DECR -> 0x5958, wrap=0.
REQ-035 LOAD 0xFFFF -> 0x5959; LOAD 0x7A3C -> 0x5939; ctrl=6 -> value held.
REQ-036 INCR every cycle from 0x0000, async_nreset pulsed low between edges at count 0x0123 -> immediate 0x0000, counting resumes 0x0001 after release.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// -----------------------------------------------------------------------------
// mod_counter_pkg
// Shared definitions for the cascaded modulo counter chain.
//   CTRL_W      : width of the ctrl operation-select bus
//   ctrl_e      : ctrl encodings (NONE, INCR, LOAD, CLR, DECR); codes 5..7 are
//                 not enumerated and are treated as NONE by the chain
//   mod_value() : turns a per-digit modulus field into the modulus as an int
// -----------------------------------------------------------------------------
package mod_counter_pkg;

  localparam int CTRL_W = 3;

  typedef enum logic [CTRL_W-1:0] {
    CTRL_NONE = 3'd0,
    CTRL_INCR = 3'd1,
    CTRL_LOAD = 3'd2,
    CTRL_CLR  = 3'd3,
    CTRL_DECR = 3'd4
  } ctrl_e;

  // A modulus of 2^WIDTH does not fit in a WIDTH-bit field, so a field of
  // zero (never a legal modulus) stands for the full 2^WIDTH range.
  function automatic int mod_value(input logic [7:0] field, input int width);
    if (field == 8'd0) begin
      return (1 << width);
    end
    return int'(field);
  endfunction

endpackage : mod_counter_pkg

// File: rtl/mod_digit.sv
// -----------------------------------------------------------------------------
// mod_digit
// One modulo-MOD digit register with clear, saturating load, increment with
// carry-around and decrement with borrow-around.
//   clk          : rising-edge clock
//   async_nreset : asynchronous active-low reset, clears the digit
//   inc_en       : increment this digit this cycle (carry already resolved)
//   dec_en       : decrement this digit this cycle (borrow already resolved)
//   load         : write d, saturated to MOD-1 when d >= MOD
//   clr          : force the digit to 0
//   d            : load value
//   q            : current digit value (always < MOD)
//   at_max       : q == MOD-1, feeds the carry chain
//   at_zero      : q == 0, feeds the borrow chain
// Priority when several controls are high: clr, load, inc_en, dec_en. The
// chain decodes one operation per cycle, so they are mutually exclusive in use.
// -----------------------------------------------------------------------------
module mod_digit #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             async_nreset,
  input  logic             inc_en,
  input  logic             dec_en,
  input  logic             load,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             at_max,
  output logic             at_zero
);

  // The modulus can be 2^WIDTH, so the compare against the load value needs
  // one extra bit; the largest digit value always fits in WIDTH bits.
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_inc_val;
  logic [WIDTH-1:0] w_dec_val;

  assign at_max  = (r_q == MAX_V);
  assign at_zero = (r_q == '0);

  always_comb begin
    w_load_val = d;
    if ({1'b0, d} >= MOD_W) begin
      w_load_val = MAX_V;
    end
  end

  // Wrap explicitly at MOD-1 / 0 so no value >= MOD is ever produced.
  assign w_inc_val = at_max  ? '0    : (r_q + 1'b1);
  assign w_dec_val = at_zero ? MAX_V : (r_q - 1'b1);

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= w_load_val;
    end else if (inc_en) begin
      r_q <= w_inc_val;
    end else if (dec_en) begin
      r_q <= w_dec_val;
    end
  end

  assign q = r_q;

endmodule : mod_digit

// File: rtl/mod_counter_chain.sv
// -----------------------------------------------------------------------------
// mod_counter_chain
// DIGITS cascaded modulo digits forming a mixed-radix up/down counter
// (default: a 60/60 time-style counter, digits mod 10,6,10,6 from LSB).
//   clk          : rising-edge clock
//   async_nreset : asynchronous active-low reset; clears digits and wrap
//   ctrl         : 0 NONE, 1 INCR, 2 LOAD, 3 CLR, 4 DECR, 5..7 NONE
//   data_in      : LOAD value, digit 0 in the LSBs
//   data_out     : digit registers, digit 0 in the LSBs
//   wrap         : registered pulse, the previous op wrapped the whole chain
//   zero         : combinational, all digits are 0
// Carry and borrow are resolved combinationally across all digits in the
// same cycle, so the whole chain moves in a single clock.
// -----------------------------------------------------------------------------
module mod_counter_chain
  import mod_counter_pkg::*;
#(
  parameter int                        DIGITS = 4,
  parameter int                        WIDTH  = 4,
  parameter logic [DIGITS*WIDTH-1:0]   MODS   = {4'd6, 4'd10, 4'd6, 4'd10}
) (
  input  logic                      clk,
  input  logic                      async_nreset,
  input  logic [CTRL_W-1:0]         ctrl,
  input  logic [DIGITS*WIDTH-1:0]   data_in,
  output logic [DIGITS*WIDTH-1:0]   data_out,
  output logic                      wrap,
  output logic                      zero
);

  logic              w_op_incr;
  logic              w_op_decr;
  logic              w_op_load;
  logic              w_op_clr;
  logic [DIGITS-1:0] w_at_max;
  logic [DIGITS-1:0] w_at_zero;
  logic [DIGITS-1:0] w_inc_en;
  logic [DIGITS-1:0] w_dec_en;
  logic              w_wrap_nxt;
  logic              r_wrap;

  // Operation decode; unlisted codes fall through as NONE.
  always_comb begin
    w_op_incr = 1'b0;
    w_op_decr = 1'b0;
    w_op_load = 1'b0;
    w_op_clr  = 1'b0;
    case (ctrl)
      CTRL_INCR: w_op_incr = 1'b1;
      CTRL_DECR: w_op_decr = 1'b1;
      CTRL_LOAD: w_op_load = 1'b1;
      CTRL_CLR:  w_op_clr  = 1'b1;
      default:   ;
    endcase
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    localparam int M = mod_value(8'(MODS[i*WIDTH +: WIDTH]), WIDTH);
    // Bits below digit i are set; bits at and above are forced to 1 so
    // the reduction-AND only looks at the lower digits.
    localparam logic [DIGITS-1:0] LOW_MASK = DIGITS'((64'd1 << i) - 64'd1);

    logic [WIDTH-1:0] w_q;

    assign w_inc_en[i] = w_op_incr & (&(w_at_max  | ~LOW_MASK));
    assign w_dec_en[i] = w_op_decr & (&(w_at_zero | ~LOW_MASK));

    mod_digit #(
      .WIDTH (WIDTH),
      .MOD   (M)
    ) u_digit (
      .clk          (clk),
      .async_nreset (async_nreset),
      .inc_en       (w_inc_en[i]),
      .dec_en       (w_dec_en[i]),
      .load         (w_op_load),
      .clr          (w_op_clr),
      .d            (data_in[i*WIDTH +: WIDTH]),
      .q            (w_q),
      .at_max       (w_at_max[i]),
      .at_zero      (w_at_zero[i])
    );

    assign data_out[i*WIDTH +: WIDTH] = w_q;
  end

  // The whole chain wraps only when every digit carries (or borrows).
  assign w_wrap_nxt = (w_op_incr & (&w_at_max)) | (w_op_decr & (&w_at_zero));

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_wrap_nxt;
    end
  end

  assign wrap = r_wrap;
  assign zero = (data_out == '0);

endmodule : mod_counter_chain

// File: tb/tb_mod_counter_chain.sv
// -----------------------------------------------------------------------------
// tb_mod_counter_chain
// Self-checking bench for mod_counter_chain at DIGITS=4, WIDTH=4, default MODS.
// The reference model holds the counter as one integer in 0..3599 and converts
// it to/from the mixed-radix digit bus (radices 10,6,10,6 from the LSB).
// -----------------------------------------------------------------------------
module tb_mod_counter_chain;
  import mod_counter_pkg::*;

  localparam int DIGITS = 4;
  localparam int WIDTH  = 4;
  localparam int BW     = DIGITS * WIDTH;
  localparam int MODV [DIGITS] = '{10, 6, 10, 6};
  localparam int TOTAL  = 3600;

  // ---------------- clock / reset ----------------
  logic              clk;
  logic              async_nreset;
  logic [CTRL_W-1:0] ctrl;
  logic [BW-1:0]     data_in;
  logic [BW-1:0]     data_out;
  logic              wrap;
  logic              zero;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mod_counter_chain #(
    .DIGITS (DIGITS),
    .WIDTH  (WIDTH),
    .MODS   ({4'd6, 4'd10, 4'd6, 4'd10})
  ) dut (
    .clk          (clk),
    .async_nreset (async_nreset),
    .ctrl         (ctrl),
    .data_in      (data_in),
    .data_out     (data_out),
    .wrap         (wrap),
    .zero         (zero)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int   m_n    = 0;
  logic m_wrap = 1'b0;

  function automatic logic [BW-1:0] n_to_bus(input int n);
    logic [BW-1:0] b;
    int            r;
    b = '0;
    r = n;
    for (int i = 0; i < DIGITS; i++) begin
      b[i*WIDTH +: WIDTH] = WIDTH'(r % MODV[i]);
      r = r / MODV[i];
    end
    return b;
  endfunction

  function automatic int bus_to_n(input logic [BW-1:0] b);
    int n;
    int w;
    int f;
    n = 0;
    w = 1;
    for (int i = 0; i < DIGITS; i++) begin
      f = int'(b[i*WIDTH +: WIDTH]);
      if (f >= MODV[i]) f = MODV[i] - 1;
      n = n + f * w;
      w = w * MODV[i];
    end
    return n;
  endfunction

  always @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      m_n    = 0;
      m_wrap = 1'b0;
    end else begin
      m_wrap = 1'b0;
      case (ctrl)
        CTRL_INCR: begin
          m_wrap = (m_n == TOTAL - 1);
          m_n    = (m_n + 1) % TOTAL;
        end
        CTRL_DECR: begin
          m_wrap = (m_n == 0);
          m_n    = (m_n + TOTAL - 1) % TOTAL;
        end
        CTRL_LOAD: m_n = bus_to_n(data_in);
        CTRL_CLR:  m_n = 0;
        default:   ;
      endcase
    end
  end

  // Compare process: every falling edge once the bench is past the first reset.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_data", 32'(data_out), 32'(n_to_bus(m_n)));
      check("cmp_wrap", 32'(wrap), 32'(m_wrap));
      check("cmp_zero", 32'(zero), 32'(m_n == 0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic op(input logic [CTRL_W-1:0] c, input logic [BW-1:0] d);
    ctrl    = c;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [BW-1:0] d, input logic w);
    check({name, "_data"}, 32'(data_out), 32'(d));
    check({name, "_wrap"}, 32'(wrap), 32'(w));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    async_nreset = 1'b1;
    ctrl         = CTRL_NONE;
    data_in      = '0;
    #1 async_nreset = 1'b0;
    #1;
    check("rst_async_data", 32'(data_out), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    async_nreset = 1'b1;
    chk_en       = 1'b1;
    @(posedge clk);
    #1;
    expect_out("reset", 16'h0000, 1'b0);
    check("reset_zero", 32'(zero), 32'h1);

    // Full-chain carry wrap, then the pulse must drop.
    op(CTRL_LOAD, 16'h5959);
    expect_out("load_5959", 16'h5959, 1'b0);
    check("load_5959_zero", 32'(zero), 32'h0);
    op(CTRL_INCR, 16'h0);
    expect_out("incr_wrap", 16'h0000, 1'b1);
    check("incr_wrap_zero", 32'(zero), 32'h1);
    op(CTRL_NONE, 16'h0);
    expect_out("wrap_one_cycle", 16'h0000, 1'b0);

    // Partial carries.
    op(CTRL_LOAD, 16'h0959);
    op(CTRL_INCR, 16'h0);
    expect_out("incr_0959", 16'h1000, 1'b0);
    op(CTRL_LOAD, 16'h0009);
    op(CTRL_INCR, 16'h0);
    expect_out("incr_0009", 16'h0010, 1'b0);

    // Full-chain borrow wrap, then an ordinary decrement.
    op(CTRL_CLR, 16'h0);
    expect_out("clr", 16'h0000, 1'b0);
    op(CTRL_DECR, 16'h0);
    expect_out("decr_wrap", 16'h5959, 1'b1);
    op(CTRL_DECR, 16'h0);
    expect_out("decr_5959", 16'h5958, 1'b0);
    op(CTRL_LOAD, 16'h1000);
    op(CTRL_DECR, 16'h0);
    expect_out("decr_1000", 16'h0959, 1'b0);
    op(CTRL_LOAD, 16'h0500);
    op(CTRL_DECR, 16'h0);
    expect_out("decr_0500", 16'h0459, 1'b0);

    // Saturating loads and the reserved codes.
    op(CTRL_LOAD, 16'hFFFF);
    expect_out("load_ffff", 16'h5959, 1'b0);
    op(CTRL_LOAD, 16'h7A3C);
    expect_out("load_7a3c", 16'h5939, 1'b0);
    op(3'd6, 16'h1234);
    expect_out("ctrl6_hold", 16'h5939, 1'b0);
    op(3'd5, 16'h1234);
    op(3'd7, 16'h1234);
    expect_out("ctrl57_hold", 16'h5939, 1'b0);

    // LOAD right after a wrap must not assert wrap.
    op(CTRL_LOAD, 16'h5959);
    op(CTRL_INCR, 16'h0);
    op(CTRL_LOAD, 16'h1234);
    expect_out("load_after_wrap", 16'h1234, 1'b0);

    // Reset while a wrap pulse is showing.
    op(CTRL_LOAD, 16'h5959);
    op(CTRL_INCR, 16'h0);
    #2 async_nreset = 1'b0;
    #1;
    expect_out("rst_kills_wrap", 16'h0000, 1'b0);
    @(negedge clk);
    #1 async_nreset = 1'b1;
    @(posedge clk);
    #1;
    expect_out("after_rst_incr", 16'h0001, 1'b0);

    // Count to 0x0123 (83 increments), reset between edges, then resume.
    op(CTRL_CLR, 16'h0);
    for (int k = 0; k < 83; k++) op(CTRL_INCR, 16'h0);
    expect_out("count_0123", 16'h0123, 1'b0);
    #2 async_nreset = 1'b0;
    #1;
    expect_out("rst_mid_count", 16'h0000, 1'b0);
    check("rst_mid_count_zero", 32'(zero), 32'h1);
    @(negedge clk);
    #1 async_nreset = 1'b1;
    @(posedge clk);
    #1;
    expect_out("resume_0001", 16'h0001, 1'b0);
    op(CTRL_INCR, 16'h0);
    expect_out("resume_0002", 16'h0002, 1'b0);

    // Mixed traffic checked by the model only.
    for (int k = 0; k < 300; k++) begin
      op(CTRL_W'($urandom_range(0, 7)), BW'($urandom()));
    end
    // Long decrement run through many borrows.
    op(CTRL_LOAD, 16'h0101);
    for (int k = 0; k < 70; k++) op(CTRL_DECR, 16'h0);

    op(CTRL_NONE, 16'h0);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mod_counter_chain
